// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : R-type field layout, NOP, funct codes and issue FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = 6;
    localparam int RS_LSB     = 21;
    localparam int RS_W       = 5;
    localparam int RT_LSB     = 16;
    localparam int RT_W       = 5;
    localparam int RD_LSB     = 11;
    localparam int RD_W       = 5;
    localparam int SHAMT_LSB  = 6;
    localparam int SHAMT_W    = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int FUNCT_W    = 6;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } issue_state_t;

    function automatic logic [31:0] mips_rtype(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] shamt,
        input logic [5:0] funct
    );
        logic [31:0] w_word;
        w_word = '0;
        w_word[RS_LSB    +: RS_W]    = rs;
        w_word[RT_LSB    +: RT_W]    = rt;
        w_word[RD_LSB    +: RD_W]    = rd;
        w_word[SHAMT_LSB +: SHAMT_W] = shamt;
        w_word[FUNCT_LSB +: FUNCT_W] = funct;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_prog_ram.sv
`default_nettype none
// ============================================================================
// Module   : mips_prog_ram
// Brief    : DEPTH x 32 program store, one write port, one registered
//            write-first read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module mips_prog_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [31:0]   i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [31:0]   o_rd_data
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/mips_instr_issue.sv
`default_nettype none
// ============================================================================
// Module   : mips_instr_issue
// Brief    : Host-loaded program buffer issuing one R-type word per accepted
//            transfer. Define MIPS_ISSUE_LOOP_EN to wrap and repeat forever.
// Revision : 1.0 - initial release
// ============================================================================
module mips_instr_issue
    import mips_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          core_ready,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic [AW:0]   pc,
    output logic          busy,
    output logic          done,
    output logic          load_err
);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_one     = (AW+1)'(1);
    localparam logic [AW-1:0] c_addr_one = AW'(1);

    issue_state_t  r_state;
    issue_state_t  w_next_state;
    logic [AW:0]   r_pc;
    logic [AW:0]   r_len_q;
    logic          r_done;
    logic          r_load_err;
    logic          w_valid;
    logic          w_busy;
    logic          w_transfer;
    logic          w_last;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic [31:0]   w_rd_data;
    logic [AW:0]   w_len_clamped;

    assign w_len_clamped = (prog_len > c_depth) ? c_depth : prog_len;
    assign w_transfer    = w_valid & core_ready;
    assign w_last        = (r_pc == r_len_q - c_one);
    assign w_wr_en       = load_en & ~w_busy;
    // Read address runs one word ahead of pc so back-to-back transfers need no bubble
    assign w_rd_en       = (r_state == FETCH) | w_transfer;
    assign w_rd_addr     = (r_state == ISSUE && !w_last) ? (r_pc[AW-1:0] + c_addr_one) : '0;

    mips_prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (load_addr),
        .i_wr_data (load_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (w_len_clamped == '0) ? DONE : FETCH;
                end
            end
            FETCH: w_next_state = ISSUE;
            ISSUE: begin
`ifdef MIPS_ISSUE_LOOP_EN
                w_next_state = ISSUE;
`else
                if (w_transfer && w_last) begin
                    w_next_state = DONE;
                end
`endif
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_valid = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            FETCH: w_busy = 1'b1;
            ISSUE: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
            end
            default: begin
                w_valid = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_len_q    <= '0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_load_err <= load_en & w_busy;
            if (r_state == IDLE && start) begin
                r_pc    <= '0;
                r_len_q <= w_len_clamped;
                if (w_len_clamped == '0) begin
                    r_done <= 1'b1;
                end
            end else if (w_transfer) begin
                if (w_last) begin
                    r_done <= 1'b1;
`ifdef MIPS_ISSUE_LOOP_EN
                    r_pc   <= '0;
`endif
                end else begin
                    r_pc <= r_pc + c_one;
                end
            end
        end
    end

    assign instr       = w_valid ? w_rd_data : MIPS_NOP;
    assign instr_valid = w_valid;
    assign pc          = r_pc;
    assign busy        = w_busy;
    assign done        = r_done;
    assign load_err    = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_instr_issue
// Brief    : Directed and randomized checks of mips_instr_issue against a
//            word-list reference of the loaded program.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_instr_issue;
    import mips_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          core_ready;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [AW:0]   pc;
    logic          busy;
    logic          done;
    logic          load_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic [5:0]  funct_tbl [5] = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};

    mips_instr_issue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .start       (start),
        .core_ready  (core_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_word(input int op);
        return mips_rtype(5'($urandom), 5'($urandom), 5'($urandom), 5'd0, funct_tbl[op]);
    endfunction

    task automatic load_word(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        tick();
        load_en   = 1'b0;
        model_mem[addr] = data;
        chk("load_no_err", {31'd0, load_err}, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, MIPS_NOP);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
    endtask

    // Issue one program and compare each cycle with the expected word list
    task automatic run_prog(input int len, input int stall_at, input int stall_n,
                            input bit rand_ready, input bit ld, input int la,
                            input logic [31:0] ldd);
        int  eff;
        int  issued;
        int  cyc;
        int  stalls;
        bit  rdy;
        eff = (len > DEPTH) ? DEPTH : len;
        if (ld) begin
            load_en   = 1'b1;
            load_addr = AW'(la);
            load_data = ldd;
            model_mem[la] = ldd;
        end
        prog_len = (AW+1)'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        load_en  = 1'b0;
        chk("n1_valid", {31'd0, instr_valid}, 32'd0);
        chk("n1_instr", instr, MIPS_NOP);
        chk("n1_busy",  {31'd0, busy}, (eff != 0) ? 32'd1 : 32'd0);
        chk("n1_done",  {31'd0, done}, (eff == 0) ? 32'd1 : 32'd0);
        if (eff == 0) begin
            tick();
            check_idle("len0_after");
            return;
        end
        tick();
        issued = 0;
        cyc    = 0;
        stalls = 0;
        while (issued < eff && cyc < 400) begin
            chk("iss_valid", {31'd0, instr_valid}, 32'd1);
            chk("iss_pc",    {27'd0, pc}, 32'(issued));
            chk("iss_instr", instr, model_mem[issued]);
            chk("iss_busy",  {31'd0, busy}, 32'd1);
            chk("iss_done",  {31'd0, done}, 32'd0);
            if (issued == stall_at && stalls < stall_n) begin
                rdy = 1'b0;
                stalls++;
            end else if (rand_ready) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            core_ready = rdy;
            start      = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            if (rdy) issued++;
            cyc++;
        end
        core_ready = 1'b0;
        chk("iss_count", 32'(issued), 32'(eff));
`ifdef MIPS_ISSUE_LOOP_EN
        chk("wrap_done",  {31'd0, done}, 32'd1);
        chk("wrap_valid", {31'd0, instr_valid}, 32'd1);
        chk("wrap_pc",    {27'd0, pc}, 32'd0);
        chk("wrap_instr", instr, model_mem[0]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("wrap_reset");
`else
        chk("end_done",  {31'd0, done}, 32'd1);
        chk("end_valid", {31'd0, instr_valid}, 32'd0);
        chk("end_instr", instr, MIPS_NOP);
        chk("end_busy",  {31'd0, busy}, 32'd0);
        chk("end_pc",    {27'd0, pc}, 32'(eff - 1));
        tick();
        check_idle("end_after");
`endif
    endtask

    initial begin
        reset      = 1'b1;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        prog_len   = '0;
        start      = 1'b0;
        core_ready = 1'b0;
        tick();
        tick();
        check_idle("reset");
        chk("reset_pc",  {27'd0, pc}, 32'd0);
        chk("reset_err", {31'd0, load_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Four-word add/sub/and/or program, then the same with a 3-cycle stall at pc=1
        for (int i = 0; i < 4; i++) load_word(i, rand_word(i));
        run_prog(4, -1, 0, 1'b0, 1'b0, 0, 32'd0);
        run_prog(4, 1, 3, 1'b0, 1'b0, 0, 32'd0);

        // Empty program
        run_prog(0, -1, 0, 1'b0, 1'b0, 0, 32'd0);

        // Load while issuing is dropped and flagged
        prog_len = 5'd4;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        load_en   = 1'b1;
        load_addr = 4'd2;
        load_data = 32'hDEAD_BEEF;
        tick();
        load_en = 1'b0;
        chk("lerr_pulse", {31'd0, load_err}, 32'd1);
        chk("lerr_pc",    {27'd0, pc}, 32'd0);
        tick();
        chk("lerr_clear", {31'd0, load_err}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_prog(4, -1, 0, 1'b0, 1'b0, 0, 32'd0);

        // Reset mid-run at pc=2, then restart from pc=0
        prog_len   = 5'd4;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        core_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_pc", {27'd0, pc}, 32'd2);
        reset      = 1'b1;
        core_ready = 1'b0;
        tick();
        reset = 1'b0;
        check_idle("mid_reset");
        chk("mid_reset_pc",  {27'd0, pc}, 32'd0);
        chk("mid_reset_err", {31'd0, load_err}, 32'd0);
        run_prog(4, -1, 0, 1'b0, 1'b0, 0, 32'd0);

        // Random full programs, random lengths (some above DEPTH), random back-pressure
        for (int i = 0; i < DEPTH; i++) load_word(i, rand_word(int'($urandom_range(0, 4))));
        for (int t = 0; t < 6; t++) begin
            run_prog(int'($urandom_range(1, 31)), -1, 0, 1'b1, 1'b0, 0, 32'd0);
        end
        run_prog(DEPTH, -1, 0, 1'b0, 1'b0, 0, 32'd0);

        // Load and start in the same cycle: the new word at address 0 must issue
        run_prog(3, -1, 0, 1'b0, 1'b1, 0, rand_word(4));

`ifdef MIPS_ISSUE_LOOP_EN
        prog_len = 5'd16;
        start    = 1'b1;
        tick();
        start      = 1'b0;
        core_ready = 1'b1;
        tick();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            chk("loop_valid", {31'd0, instr_valid}, 32'd1);
            chk("loop_busy",  {31'd0, busy}, 32'd1);
            chk("loop_pc",    {27'd0, pc}, 32'(i % DEPTH));
            chk("loop_instr", instr, model_mem[i % DEPTH]);
            chk("loop_done",  {31'd0, done}, (i > 0 && (i % DEPTH) == 0) ? 32'd1 : 32'd0);
            tick();
        end
        reset      = 1'b1;
        core_ready = 1'b0;
        tick();
        reset = 1'b0;
        check_idle("loop_exit");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
